// File: rtl/eth_rx_drain.sv
// Purpose : drains one packet at a time from the MAC receive buffer onto an AXI-Stream master, then releases the buffer.
// Latency : first buffer read one cycle after rx_ready_i is seen in IDLE; first tvalid two cycles after that read; one beat/cycle sustained.
// Backpres: reads are throttled by a 2-entry output FIFO (occupancy + in-flight < 2), so no returned word is ever dropped.
//
// Ports: clk_i/reset_n_i (async active-low); rx_ready_i/rx_packet_size_i from the buffer;
//        buffer_read_addr_o/buffer_read_v_o/buffer_read_data_i read port (1-cycle latency);
//        m_axis_* stream master; clear_buffer_o release pulse; busy_o, packet_count_o, drop_count_o status.
// Optional feature: define ETH_RX_DRAIN_LEN_CHECK_EN to drop sizes < 14 or > buf_size_p and count them.
module eth_rx_drain #(
    parameter int buf_size_p   = 2048,
    parameter int axis_width_p = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          rx_ready_i,
    input  logic [15:0]                   rx_packet_size_i,
    output logic                          clear_buffer_o,
    output logic [$clog2(buf_size_p)-1:0] buffer_read_addr_o,
    output logic                          buffer_read_v_o,
    input  logic [axis_width_p-1:0]       buffer_read_data_i,
    output logic [axis_width_p-1:0]       m_axis_tdata_o,
    output logic [axis_width_p/8-1:0]     m_axis_tkeep_o,
    output logic                          m_axis_tvalid_o,
    output logic                          m_axis_tlast_o,
    input  logic                          m_axis_tready_i,
    output logic                          busy_o,
    output logic [15:0]                   packet_count_o,
    output logic [15:0]                   drop_count_o
);

    localparam int BYTES_P = axis_width_p / 8;
    localparam int AW_P    = $clog2(buf_size_p);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_CLEAR  = 2'd2,
        S_DRAIN  = 2'd3
    } state_e;

    state_e            state_q;
    logic [15:0]       size_q;
    logic [15:0]       beats_q;
    logic [15:0]       rd_cnt_q;     // reads issued for this packet
    logic [15:0]       ret_cnt_q;    // words returned into the FIFO
    logic [AW_P-1:0]   addr_q;
    logic              inflight_q;   // a read was issued last cycle
    logic              streamed_q;   // current packet produces beats
    logic              clear_q;
    logic [15:0]       pkt_cnt_q;

    // Output FIFO, two entries
    logic [axis_width_p-1:0] fifo_dat_q  [2];
    logic [BYTES_P-1:0]      fifo_keep_q [2];
    logic                    fifo_last_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              fifo_cnt_q;

    logic                    push;
    logic                    pop;
    logic [1:0]              occ_after_pop;
    logic                    rd_v;
    logic                    beat_is_last;

    // ------------------------------------------------------------------
    // Size qualification in IDLE
    // ------------------------------------------------------------------
    logic [15:0] size_eff;
    logic [15:0] beats_calc;
    logic        no_stream;
`ifdef ETH_RX_DRAIN_LEN_CHECK_EN
    logic        drop_now;
    logic        dropped_q;
    logic [15:0] drop_cnt_q;
`endif

    always_comb begin
        size_eff  = rx_packet_size_i;
        no_stream = 1'b0;
`ifdef ETH_RX_DRAIN_LEN_CHECK_EN
        drop_now  = (rx_packet_size_i < 16'd14) || (32'(rx_packet_size_i) > 32'(buf_size_p));
        no_stream = drop_now;
`else
        if (32'(rx_packet_size_i) > 32'(buf_size_p)) begin
            size_eff = 16'(buf_size_p);
        end
        no_stream = (rx_packet_size_i == 16'd0);
`endif
        beats_calc = (size_eff + 16'(BYTES_P - 1)) / 16'(BYTES_P);
    end

    // Last-beat byte enables: low (size mod B) bytes, or all when the size is a whole number of words
    logic [15:0]        rem;
    logic [BYTES_P-1:0] keep_last;

    always_comb begin
        rem       = size_q % 16'(BYTES_P);
        keep_last = '0;
        for (int i = 0; i < BYTES_P; i++) begin
            keep_last[i] = (rem == 16'd0) || (16'(i) < rem);
        end
    end

    // ------------------------------------------------------------------
    // Read issue and FIFO control
    // ------------------------------------------------------------------
    assign push            = inflight_q;
    assign m_axis_tvalid_o = (fifo_cnt_q != 2'd0);
    assign pop             = m_axis_tvalid_o && m_axis_tready_i;
    // Occupancy is taken after this cycle's pop so a full-rate stream keeps one read in flight every cycle.
    assign occ_after_pop   = fifo_cnt_q - {1'b0, pop};
    assign rd_v            = (state_q == S_STREAM) && (rd_cnt_q < beats_q) &&
                             ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);
    assign beat_is_last    = (ret_cnt_q == beats_q - 16'd1);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 2; i++) begin
                fifo_dat_q[i]  <= '0;
                fifo_keep_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_dat_q[wr_ptr_q]  <= buffer_read_data_i;
                fifo_keep_q[wr_ptr_q] <= beat_is_last ? keep_last : '1;
                fifo_last_q[wr_ptr_q] <= beat_is_last;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            size_q     <= 16'd0;
            beats_q    <= 16'd0;
            rd_cnt_q   <= 16'd0;
            ret_cnt_q  <= 16'd0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            streamed_q <= 1'b0;
            clear_q    <= 1'b0;
            pkt_cnt_q  <= 16'd0;
`ifdef ETH_RX_DRAIN_LEN_CHECK_EN
            dropped_q  <= 1'b0;
            drop_cnt_q <= 16'd0;
`endif
        end else begin
            inflight_q <= rd_v;
            if (push) begin
                ret_cnt_q <= ret_cnt_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    clear_q <= 1'b0;
                    if (rx_ready_i) begin
                        size_q     <= size_eff;
                        beats_q    <= no_stream ? 16'd0 : beats_calc;
                        rd_cnt_q   <= 16'd0;
                        ret_cnt_q  <= 16'd0;
                        addr_q     <= '0;
                        streamed_q <= !no_stream;
`ifdef ETH_RX_DRAIN_LEN_CHECK_EN
                        dropped_q  <= drop_now;
`endif
                        if (no_stream) begin
                            state_q <= S_CLEAR;
                            clear_q <= 1'b1;
                        end else begin
                            state_q <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (rd_v) begin
                        addr_q   <= addr_q + AW_P'(BYTES_P);
                        rd_cnt_q <= rd_cnt_q + 16'd1;
                    end
                    // tlast leaving the FIFO means every read has returned and been consumed
                    if (pop && m_axis_tlast_o) begin
                        state_q <= S_CLEAR;
                        clear_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clear_q <= 1'b0;
                    if (streamed_q) begin
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    end
`ifdef ETH_RX_DRAIN_LEN_CHECK_EN
                    if (dropped_q) begin
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end
`endif
                    state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Hold here until the MAC drops rx_ready so the released packet is not streamed twice
                    if (!rx_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign clear_buffer_o     = clear_q;
    assign buffer_read_addr_o = addr_q;
    assign buffer_read_v_o    = rd_v;
    assign m_axis_tdata_o     = fifo_dat_q[rd_ptr_q];
    assign m_axis_tkeep_o     = fifo_keep_q[rd_ptr_q];
    assign m_axis_tlast_o     = fifo_last_q[rd_ptr_q];
    assign busy_o             = (state_q != S_IDLE);
    assign packet_count_o     = pkt_cnt_q;
`ifdef ETH_RX_DRAIN_LEN_CHECK_EN
    assign drop_count_o       = drop_cnt_q;
`else
    assign drop_count_o       = 16'd0;
`endif

endmodule

// File: tb/tb_eth_rx_drain.sv
// Purpose : randomized self-checking bench for eth_rx_drain against a packet-level reference model.
// Latency : checks read/tvalid/clear timing relative to rx_ready and the last handshake.
// Backpres: drives tready constant, toggling or random; checks hold-while-stalled.
module tb_eth_rx_drain;

    localparam int BUF = 2048;
    localparam int W   = 64;
    localparam int B   = 8;
    localparam int AW  = 11;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          rx_ready_i = 1'b0;
    logic [15:0]   rx_packet_size_i = 16'd0;
    logic          clear_buffer_o;
    logic [AW-1:0] buffer_read_addr_o;
    logic          buffer_read_v_o;
    logic [W-1:0]  buffer_read_data_i = '0;
    logic [W-1:0]  m_axis_tdata_o;
    logic [B-1:0]  m_axis_tkeep_o;
    logic          m_axis_tvalid_o;
    logic          m_axis_tlast_o;
    logic          m_axis_tready_i = 1'b1;
    logic          busy_o;
    logic [15:0]   packet_count_o;
    logic [15:0]   drop_count_o;

    eth_rx_drain #(.buf_size_p(BUF), .axis_width_p(W)) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .rx_ready_i         (rx_ready_i),
        .rx_packet_size_i   (rx_packet_size_i),
        .clear_buffer_o     (clear_buffer_o),
        .buffer_read_addr_o (buffer_read_addr_o),
        .buffer_read_v_o    (buffer_read_v_o),
        .buffer_read_data_i (buffer_read_data_i),
        .m_axis_tdata_o     (m_axis_tdata_o),
        .m_axis_tkeep_o     (m_axis_tkeep_o),
        .m_axis_tvalid_o    (m_axis_tvalid_o),
        .m_axis_tlast_o     (m_axis_tlast_o),
        .m_axis_tready_i    (m_axis_tready_i),
        .busy_o             (busy_o),
        .packet_count_o     (packet_count_o),
        .drop_count_o       (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Receive buffer model: one word per B bytes, data one cycle after the read request
    logic [W-1:0] mem [256];
    always @(posedge clk_i) begin
        if (buffer_read_v_o) buffer_read_data_i <= mem[buffer_read_addr_o[AW-1:3]];
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Ready driver
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       m_axis_tready_i = 1'b1;
                1:       m_axis_tready_i = ~m_axis_tready_i;
                default: m_axis_tready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor
    logic [W-1:0]  cap_dat  [$];
    logic [B-1:0]  cap_keep [$];
    logic          cap_last [$];
    logic [AW-1:0] cap_addr [$];
    int hs_first, hs_last, rd_first, vld_first, clr_cnt, clr_cyc, rise_cyc;
    logic          stall_q = 1'b0;
    logic [W-1:0]  st_dat;
    logic [B-1:0]  st_keep;
    logic          st_last;

    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check_eq("stall_tvalid", 64'(m_axis_tvalid_o), 64'd1);
                check_eq("stall_tdata", m_axis_tdata_o, st_dat);
                check_eq("stall_tkeep", 64'(m_axis_tkeep_o), 64'(st_keep));
                check_eq("stall_tlast", 64'(m_axis_tlast_o), 64'(st_last));
            end
            if (m_axis_tvalid_o && vld_first < 0) vld_first = cyc;
            if (m_axis_tvalid_o && m_axis_tready_i) begin
                cap_dat.push_back(m_axis_tdata_o);
                cap_keep.push_back(m_axis_tkeep_o);
                cap_last.push_back(m_axis_tlast_o);
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
            end
            if (buffer_read_v_o) begin
                cap_addr.push_back(buffer_read_addr_o);
                if (rd_first < 0) rd_first = cyc;
            end
            if (clear_buffer_o) begin
                clr_cnt++;
                clr_cyc = cyc;
            end
            stall_q = m_axis_tvalid_o && !m_axis_tready_i;
            st_dat  = m_axis_tdata_o;
            st_keep = m_axis_tkeep_o;
            st_last = m_axis_tlast_o;
        end
    end

    task automatic clear_caps();
        cap_dat.delete();
        cap_keep.delete();
        cap_last.delete();
        cap_addr.delete();
        hs_first = -1; hs_last = -1; rd_first = -1; vld_first = -1;
        clr_cnt = 0; clr_cyc = -1;
    endtask

    // Reference model: packet-level outcome of a given size
    int exp_pkt  = 0;
    int exp_drop = 0;

    function automatic void expect_pkt(input int s, output int n, output logic [B-1:0] lkeep,
                                       output bit streamed, output bit dropped);
        int eff;
        eff      = s;
        dropped  = 1'b0;
        streamed = 1'b1;
`ifdef ETH_RX_DRAIN_LEN_CHECK_EN
        if (s < 14 || s > BUF) begin
            dropped  = 1'b1;
            streamed = 1'b0;
        end
`else
        if (s == 0) streamed = 1'b0;
        if (eff > BUF) eff = BUF;
`endif
        n     = streamed ? (eff + B - 1) / B : 0;
        lkeep = (eff % B == 0) ? 8'hFF : 8'((1 << (eff % B)) - 1);
    endfunction

    task automatic start_pkt(input int s);
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        clear_caps();
        rx_packet_size_i = 16'(s);
        rx_ready_i       = 1'b1;
        rise_cyc         = cyc;
    endtask

    task automatic finish_pkt(input int s, input int hold);
        int n, budget;
        logic [B-1:0] lk;
        bit st, dr;
        expect_pkt(s, n, lk, st, dr);
        budget = 0;
        while (clr_cnt == 0 && budget < 6000) begin
            @(posedge clk_i);
            budget++;
        end
        check_eq($sformatf("clear_seen s=%0d", s), 64'(clr_cnt > 0), 64'd1);
        repeat (hold) @(posedge clk_i);
        #1 rx_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        if (st) exp_pkt = (exp_pkt + 1) % 65536;
        if (dr) exp_drop = (exp_drop + 1) % 65536;

        check_eq($sformatf("beats s=%0d", s), 64'(cap_dat.size()), 64'(n));
        check_eq($sformatf("reads s=%0d", s), 64'(cap_addr.size()), 64'(n));
        for (int i = 0; i < cap_dat.size() && i < n; i++) begin
            check_eq($sformatf("tdata s=%0d beat=%0d", s, i), cap_dat[i], mem[i]);
            check_eq($sformatf("tkeep s=%0d beat=%0d", s, i), 64'(cap_keep[i]),
                     64'((i == n - 1) ? lk : 8'hFF));
            check_eq($sformatf("tlast s=%0d beat=%0d", s, i), 64'(cap_last[i]), 64'(i == n - 1));
        end
        for (int i = 0; i < cap_addr.size() && i < n; i++) begin
            check_eq($sformatf("addr s=%0d read=%0d", s, i), 64'(cap_addr[i]), 64'(i * B));
        end
        check_eq($sformatf("clear_count s=%0d", s), 64'(clr_cnt), 64'd1);
        if (n > 0) begin
            check_eq($sformatf("rd_latency s=%0d", s), 64'(rd_first - rise_cyc), 64'd1);
            check_eq($sformatf("vld_latency s=%0d", s), 64'(vld_first - rd_first), 64'd2);
            check_eq($sformatf("clear_after_last s=%0d", s), 64'(clr_cyc - hs_last), 64'd1);
            if (rdy_mode == 0) begin
                check_eq($sformatf("throughput s=%0d", s), 64'(hs_last - hs_first), 64'(n - 1));
            end
        end else begin
            check_eq($sformatf("clear_skip_time s=%0d", s), 64'(clr_cyc - rise_cyc), 64'd1);
        end
        check_eq($sformatf("packet_count s=%0d", s), 64'(packet_count_o), 64'(exp_pkt));
        check_eq($sformatf("drop_count s=%0d", s), 64'(drop_count_o), 64'(exp_drop));
        check_eq($sformatf("busy_idle s=%0d", s), 64'(busy_o), 64'd0);
    endtask

    task automatic run_pkt(input int s, input int mode, input int hold);
        rdy_mode = mode;
        start_pkt(s);
        finish_pkt(s, hold);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_tvalid"}, 64'(m_axis_tvalid_o), 64'd0);
        check_eq({tag, "_tdata"}, m_axis_tdata_o, 64'd0);
        check_eq({tag, "_tkeep"}, 64'(m_axis_tkeep_o), 64'd0);
        check_eq({tag, "_tlast"}, 64'(m_axis_tlast_o), 64'd0);
        check_eq({tag, "_read_v"}, 64'(buffer_read_v_o), 64'd0);
        check_eq({tag, "_addr"}, 64'(buffer_read_addr_o), 64'd0);
        check_eq({tag, "_clear"}, 64'(clear_buffer_o), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, "_pkt_cnt"}, 64'(packet_count_o), 64'd0);
        check_eq({tag, "_drop_cnt"}, 64'(drop_count_o), 64'd0);
    endtask

    initial begin
        int budget;
        clear_caps();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_zero_outputs("reset");
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;

        // Directed packets
        run_pkt(64, 0, 0);
        run_pkt(61, 0, 0);
        run_pkt(100, 1, 0);
        run_pkt(5000, 0, 0);
        run_pkt(64, 0, 3);      // rx_ready held through DRAIN must not restream
        run_pkt(16, 0, 0);
        run_pkt(0, 2, 0);
        run_pkt(1, 2, 1);
        run_pkt(8, 0, 0);
        run_pkt(9, 1, 0);
        run_pkt(13, 0, 0);
        run_pkt(2048, 2, 0);
        run_pkt(2049, 0, 0);

        // Asynchronous reset at beat 4 of a 64-byte packet
        rdy_mode = 0;
        start_pkt(64);
        budget = 0;
        while (cap_dat.size() < 4 && budget < 200) begin
            @(posedge clk_i);
            budget++;
        end
        check_eq("reset_test_reach_beat4", 64'(cap_dat.size() >= 4), 64'd1);
        #1 reset_n_i = 1'b0;
        #1 check_zero_outputs("midreset");
        clear_caps();
        exp_pkt  = 0;
        exp_drop = 0;
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        rise_cyc = cyc;
        finish_pkt(64, 0);

        // Random traffic
        for (int k = 0; k < 14; k++) begin
            int s, m, h;
            s = (k % 5 == 4) ? int'($urandom_range(0, 13)) : int'($urandom_range(1, 300));
            m = int'($urandom_range(0, 2));
            h = int'($urandom_range(0, 3));
            run_pkt(s, m, h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_rx_drain.md
# eth_rx_drain

Streaming drain stage directly downstream of the MAC-with-buffer receive side. When the receive buffer reports a packet (`rx_ready_i`), the block latches the packet size and reads the buffer word by word through the read-address port. It presents the packet on an AXI-Stream master with correct `tkeep`/`tlast`, then pulses `clear_buffer_o` so the MAC can accept the next frame. It feeds host-side logic (DMA, parser) with full backpressure support.

## Interface
- `buf_size_p`, 2048: receive buffer size in bytes (power of two).
- `axis_width_p`, 64: buffer word and stream width in bits (multiple of 8, at most 512).
- `clk_i` in, 1: single clock, same as the buffer's `clk_i`.
- `reset_n_i` in, 1: asynchronous, active-low reset.
- `rx_ready_i` in, 1: buffer holds a complete packet.
- `rx_packet_size_i` in, 16: packet length in bytes; valid while `rx_ready_i` is high.
- `clear_buffer_o` out, 1: one-cycle pulse releasing the buffer.
- `buffer_read_addr_o` out, $clog2(buf_size_p): byte address, always word-aligned.
- `buffer_read_v_o` out, 1: read request.
- `buffer_read_data_i` in, axis_width_p: read data, valid exactly one cycle after `buffer_read_v_o`.
- `m_axis_tdata_o` out, axis_width_p: stream data; byte 0 of the word is on `[7:0]`.
- `m_axis_tkeep_o` out, axis_width_p/8: byte enables.
- `m_axis_tvalid_o` out, 1: stream valid.
- `m_axis_tlast_o` out, 1: last beat of the packet.
- `m_axis_tready_i` in, 1: stream ready.
- `busy_o` out, 1: high in any state other than IDLE.
- `packet_count_o` out, 16: packets fully streamed; wraps at 16 bits.
- `drop_count_o` out, 16: packets dropped; zero unless length checking is enabled.

## Operation
- B = axis_width_p/8 bytes per word. N = ceil(size/B) beats per packet.
- FSM states:
  - **IDLE**: on `rx_ready_i`=1, latch the size, reset the address to 0 and go to STREAM. A skipped or dropped size goes directly to CLEAR.
  - **STREAM**: issue reads at addresses 0, B, 2B, … up to (N−1)B. When the beat carrying `tlast` is accepted, go to CLEAR.
  - **CLEAR**: assert `clear_buffer_o` for exactly one cycle, then go to DRAIN.
  - **DRAIN**: wait for `rx_ready_i`=0, then go to IDLE. This prevents re-streaming a stale packet.
- Output buffering is a 2-entry FIFO.
  - A read is issued only when FIFO occupancy plus in-flight reads is less than 2.
  - Returned data is always written into the FIFO; data is never lost under backpressure.
- `tkeep` is all ones except on the last beat, where it has the low (size mod B) bits set. If size mod B = 0, the last beat's `tkeep` is all ones.
- `tlast` is high only on beat N−1.
- `packet_count_o` increments in the CLEAR cycle of a streamed packet only.
- Sizes 0 and 1…B are legal. Size 0 produces no beats and goes directly to CLEAR with no count change.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and the FIFO is empty.
- Reset asserted mid-packet aborts immediately: the stream is truncated with no `tlast` and there is no clear. The buffer still holds the packet, so it is re-streamed from address 0 after reset.
- `rx_ready_i` rising in IDLE → first `buffer_read_v_o` on the next cycle → first `tvalid` two cycles after that read.
- With `tready` held at 1, throughput is sustained at one beat per cycle.
- `tdata`/`tkeep`/`tlast` hold stable while `tvalid`=1 and `tready`=0. `tvalid` never drops without a handshake.
- For an N-beat packet under continuous `tready`: last handshake → `clear_buffer_o` on the next cycle → DRAIN.
- `rx_ready_i` changing during STREAM is ignored; the size is latched in IDLE.
- A drop or skip pulses `clear_buffer_o` on the cycle after the IDLE detection.

## Configuration
- `ETH_RX_DRAIN_LEN_CHECK_EN` defined:
  - Sizes below 14 or above `buf_size_p` are dropped: no beats, `clear_buffer_o` pulses, and `drop_count_o` increments (wraps at 16 bits).
- `ETH_RX_DRAIN_LEN_CHECK_EN` undefined:
  - No length checking; `drop_count_o` is tied to 0.
  - Size 0 is skipped.
  - Sizes above `buf_size_p` are clamped to `buf_size_p`.

## Test plan
- Size 64, B=8, `tready`=1 → 8 beats on consecutive cycles at addresses 0..56, last `tkeep`=0xFF, `clear_buffer_o` once, `packet_count_o`=1.
- Size 61 → 8 beats, last `tkeep`=0x1F, `tlast` only on beat 7.
- Size 100 with `tready` toggling 1/0 every cycle → 13 beats, data matches buffer words in order, outputs stable while stalled, no duplicated or missing word.
- Size 5000 with the macro defined → 0 beats, one clear pulse, `drop_count_o`=1. Without the macro → 256 beats (2048 bytes), last `tkeep`=0xFF.
- `rx_ready_i` held high for 3 cycles after the clear pulse → no second packet streamed. The next rising edge of `rx_ready_i` streams the new packet.
- `reset_n_i` pulsed low at beat 4 of a 64-byte packet with `rx_ready_i` still 1 → outputs go to 0 asynchronously. After release, the full 8-beat packet is streamed from address 0 and `packet_count_o`=1.
